// File: rtl/alu_arbiter.sv
// Two-requester arbiter sequencing a shared ALU through load-A, load-B,
// execute and capture phases, with round-robin priority on contention.
module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [3:0] op0,
  input  logic [3:0] op1,
  input  logic [1:0] sign_in,
  output logic [1:0] gnt,
  output logic [3:0] func,
  output logic       sign,
  output logic [1:0] reg_ctrl,
  output logic [1:0] done,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, CAPTURE} state_t;

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES);

  state_t     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic [3:0] func_q, func_d;
  logic       sign_q, sign_d;
  logic [1:0] reg_ctrl_q, reg_ctrl_d;
  logic [1:0] done_q, done_d;
  logic       busy_q, busy_d;
  logic       ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;

  logic win1;
  logic granted_req;

  assign win1        = (req == 2'b10) || ((req == 2'b11) && ptr_q);
  assign granted_req = |(req & gnt_q);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    func_d     = func_q;
    sign_d     = sign_q;
    reg_ctrl_d = 2'b00;
    done_d     = 2'b00;
    busy_d     = busy_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = LOAD_A;
          gnt_d      = win1 ? 2'b10 : 2'b01;
          func_d     = win1 ? op1 : op0;
          sign_d     = win1 ? sign_in[1] : sign_in[0];
          reg_ctrl_d = 2'b01;
          busy_d     = 1'b1;
        end
      end
      LOAD_A, LOAD_B, EXEC: begin
        if (!granted_req) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (state_q == LOAD_A) begin
          state_d    = LOAD_B;
          reg_ctrl_d = 2'b10;
        end else if (state_q == LOAD_B) begin
          state_d = EXEC;
          cnt_d   = EXEC_LOAD;
        end else if (cnt_q == 4'd1) begin
          // Pointer moves to the non-winner only once the operation commits.
          state_d    = CAPTURE;
          reg_ctrl_d = 2'b11;
          done_d     = gnt_q;
          ptr_d      = gnt_q[0];
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CAPTURE: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      func_q     <= '0;
      sign_q     <= 1'b0;
      reg_ctrl_q <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      ptr_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      func_q     <= func_d;
      sign_q     <= sign_d;
      reg_ctrl_q <= reg_ctrl_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign func     = func_q;
  assign sign     = sign_q;
  assign reg_ctrl = reg_ctrl_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: three instances (EXEC_CYCLES 2, 1, 15) share stimulus;
// a phase-offset transaction model predicts every output cycle by cycle.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [1:0] req = '0;
  logic [3:0] op0 = '0;
  logic [3:0] op1 = '0;
  logic [1:0] sign_in = '0;

  logic [1:0] gnt_o  [3];
  logic [3:0] func_o [3];
  logic       sign_o [3];
  logic [1:0] reg_o  [3];
  logic [1:0] done_o [3];
  logic       busy_o [3];

  int tests_run = 0;
  int tests_failed = 0;

  alu_arbiter #(.EXEC_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .op0(op0), .op1(op1), .sign_in(sign_in),
    .gnt(gnt_o[0]), .func(func_o[0]), .sign(sign_o[0]), .reg_ctrl(reg_o[0]),
    .done(done_o[0]), .busy(busy_o[0]));

  alu_arbiter #(.EXEC_CYCLES(1)) dut_e1 (
    .clk(clk), .rst(rst), .req(req), .op0(op0), .op1(op1), .sign_in(sign_in),
    .gnt(gnt_o[1]), .func(func_o[1]), .sign(sign_o[1]), .reg_ctrl(reg_o[1]),
    .done(done_o[1]), .busy(busy_o[1]));

  alu_arbiter #(.EXEC_CYCLES(15)) dut_e15 (
    .clk(clk), .rst(rst), .req(req), .op0(op0), .op1(op1), .sign_in(sign_in),
    .gnt(gnt_o[2]), .func(func_o[2]), .sign(sign_o[2]), .reg_ctrl(reg_o[2]),
    .done(done_o[2]), .busy(busy_o[2]));

  // Model: an active transaction is described by its phase, the number of
  // cycles since grant (1 = load A, 2 = load B, 3..E+2 = execute, E+3 = capture).
  int         m_e    [3] = '{2, 1, 15};
  bit         m_act  [3];
  int         m_ph   [3];
  int         m_win  [3];
  bit         m_ptr  [3];
  logic [3:0] m_func [3];
  logic       m_sign [3];

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_act[k] = 0; m_ptr[k] = 0; m_func[k] = '0; m_sign[k] = 1'b0; m_ph[k] = 0;
      end else if (!m_act[k]) begin
        if (req != 2'b00) begin
          m_win[k]  = (req == 2'b11) ? int'(m_ptr[k]) : (req[1] ? 1 : 0);
          m_act[k]  = 1;
          m_ph[k]   = 1;
          m_func[k] = (m_win[k] == 1) ? op1 : op0;
          m_sign[k] = sign_in[m_win[k]];
        end
      end else if (m_ph[k] == m_e[k] + 3) begin
        m_act[k] = 0;
      end else if (!req[m_win[k]]) begin
        m_act[k] = 0;
      end else begin
        m_ph[k] = m_ph[k] + 1;
        if (m_ph[k] == m_e[k] + 3) m_ptr[k] = (m_win[k] == 0);
      end
    end
  endtask

  function automatic logic [1:0] e_gnt(int k);
    return m_act[k] ? ((m_win[k] == 1) ? 2'b10 : 2'b01) : 2'b00;
  endfunction

  function automatic logic [1:0] e_reg(int k);
    if (!m_act[k]) return 2'b00;
    if (m_ph[k] == 1) return 2'b01;
    if (m_ph[k] == 2) return 2'b10;
    if (m_ph[k] == m_e[k] + 3) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [1:0] e_done(int k);
    return (m_act[k] && m_ph[k] == m_e[k] + 3) ? e_gnt(k) : 2'b00;
  endfunction

  // One clock: inputs stable at the rising edge, outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    op0 = 4'hF; op1 = 4'hF; sign_in = 2'b11;
    do_reset();
    tests_run++;
    if ({gnt_o[0], func_o[0], sign_o[0], reg_o[0], done_o[0], busy_o[0]} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got gnt=%b func=%h sign=%b reg=%b done=%b busy=%b, want all zero",
               gnt_o[0], func_o[0], sign_o[0], reg_o[0], done_o[0], busy_o[0]);
    end
  endtask

  task automatic test_single();
    logic [1:0] eg [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    logic [1:0] er [6] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b11, 2'b00};
    logic [1:0] ed [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    do_reset();
    req = 2'b01; op0 = 4'b0101; op1 = 4'b1010; sign_in = 2'b01;
    for (int c = 1; c <= 6; c++) begin
      tick();
      tests_run++;
      if ({gnt_o[0], reg_o[0], done_o[0]} !== {eg[c-1], er[c-1], ed[c-1]}) begin
        tests_failed++;
        $display("FAIL single_seq c=%0d: got gnt=%b reg=%b done=%b, want gnt=%b reg=%b done=%b",
                 c, gnt_o[0], reg_o[0], done_o[0], eg[c-1], er[c-1], ed[c-1]);
      end
      if (c <= 5) begin
        tests_run++;
        if ({func_o[0], sign_o[0]} !== {4'b0101, 1'b1}) begin
          tests_failed++;
          $display("FAIL single_func c=%0d: got func=%b sign=%b, want func=0101 sign=1",
                   c, func_o[0], sign_o[0]);
        end
      end
      if (c == 5) req = 2'b00;
    end
  endtask

  task automatic test_contention();
    logic [1:0] want_g;
    logic [1:0] want_d;
    do_reset();
    req = 2'b11; op0 = 4'h3; op1 = 4'hA; sign_in = 2'b10;
    for (int c = 1; c <= 12; c++) begin
      tick();
      want_g = (c <= 5) ? 2'b01 : (c == 6) ? 2'b00 : (c <= 11) ? 2'b10 : 2'b00;
      want_d = (c == 5) ? 2'b01 : (c == 11) ? 2'b10 : 2'b00;
      tests_run++;
      if ({gnt_o[0], done_o[0]} !== {want_g, want_d}) begin
        tests_failed++;
        $display("FAIL contention c=%0d: got gnt=%b done=%b, want gnt=%b done=%b",
                 c, gnt_o[0], done_o[0], want_g, want_d);
      end
      if (c == 7) begin
        tests_run++;
        if ({func_o[0], sign_o[0]} !== {4'hA, 1'b1}) begin
          tests_failed++;
          $display("FAIL contention_func: got func=%h sign=%b, want func=a sign=1",
                   func_o[0], sign_o[0]);
        end
      end
      if (c == 11) req = 2'b00;
    end
  endtask

  task automatic test_abort();
    do_reset();
    req = 2'b01; op0 = 4'h2; op1 = 4'h7; sign_in = 2'b00;
    tick(); tick(); tick();
    tests_run++;
    if ({gnt_o[0], reg_o[0], busy_o[0]} !== {2'b01, 2'b00, 1'b1}) begin
      tests_failed++;
      $display("FAIL abort_exec: got gnt=%b reg=%b busy=%b, want gnt=01 reg=00 busy=1",
               gnt_o[0], reg_o[0], busy_o[0]);
    end
    req = 2'b00;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if ({gnt_o[0], reg_o[0], done_o[0], busy_o[0]} !== 7'b0) begin
        tests_failed++;
        $display("FAIL abort_idle c=%0d: got gnt=%b reg=%b done=%b busy=%b, want all zero",
                 c, gnt_o[0], reg_o[0], done_o[0], busy_o[0]);
      end
    end
    req = 2'b11;
    tick();
    tests_run++;
    if ({gnt_o[0], func_o[0]} !== {2'b01, 4'h2}) begin
      tests_failed++;
      $display("FAIL abort_ptr: got gnt=%b func=%h, want gnt=01 func=2", gnt_o[0], func_o[0]);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_op_stability();
    do_reset();
    req = 2'b01; op0 = 4'b0101; sign_in = 2'b01;
    tick(); tick();
    tests_run++;
    if (reg_o[0] !== 2'b10) begin
      tests_failed++;
      $display("FAIL opstab_loadb: got reg=%b, want reg=10", reg_o[0]);
    end
    op0 = 4'b1111; sign_in = 2'b00;
    for (int c = 3; c <= 5; c++) begin
      tick();
      tests_run++;
      if ({func_o[0], sign_o[0], done_o[0]} !== {4'b0101, 1'b1, (c == 5) ? 2'b01 : 2'b00}) begin
        tests_failed++;
        $display("FAIL opstab c=%0d: got func=%b sign=%b done=%b, want func=0101 sign=1 done=%b",
                 c, func_o[0], sign_o[0], done_o[0], (c == 5) ? 2'b01 : 2'b00);
      end
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 2'b10; op1 = 4'h9; sign_in = 2'b10;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if ({gnt_o[0], func_o[0], sign_o[0], reg_o[0], done_o[0], busy_o[0]} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_mid: got gnt=%b func=%h sign=%b reg=%b done=%b busy=%b, want all zero",
               gnt_o[0], func_o[0], sign_o[0], reg_o[0], done_o[0], busy_o[0]);
    end
    rst = 1'b0; op1 = 4'h6;
    tick();
    tests_run++;
    if ({gnt_o[0], func_o[0], reg_o[0]} !== {2'b10, 4'h6, 2'b01}) begin
      tests_failed++;
      $display("FAIL reset_release: got gnt=%b func=%h reg=%b, want gnt=10 func=6 reg=01",
               gnt_o[0], func_o[0], reg_o[0]);
    end
    for (int c = 2; c <= 5; c++) begin
      tick();
      tests_run++;
      if (done_o[0] !== ((c == 5) ? 2'b10 : 2'b00)) begin
        tests_failed++;
        $display("FAIL reset_after_done c=%0d: got done=%b, want %b",
                 c, done_o[0], (c == 5) ? 2'b10 : 2'b00);
      end
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_latency();
    int first_done [3] = '{0, 0, 0};
    int exec_cnt   [3] = '{0, 0, 0};
    int want_done  [3] = '{5, 4, 18};
    do_reset();
    req = 2'b01; op0 = 4'hC; sign_in = 2'b00;
    for (int c = 1; c <= 25; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        if (first_done[k] == 0) begin
          if (busy_o[k] && reg_o[k] == 2'b00) exec_cnt[k]++;
          if (done_o[k] != 2'b00) first_done[k] = c;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (first_done[k] != want_done[k] || exec_cnt[k] != m_e[k]) begin
        tests_failed++;
        $display("FAIL latency E=%0d: got done at N+%0d exec=%0d, want done at N+%0d exec=%0d",
                 m_e[k], first_done[k], exec_cnt[k], want_done[k], m_e[k]);
      end
    end
    req = 2'b00;
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < 2; i++) begin
        if (req[i]) begin
          if ((done_o[0][i] && $urandom_range(0, 1) == 1) || $urandom_range(0, 59) == 0)
            req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
        end
      end
      op0 = 4'($urandom); op1 = 4'($urandom); sign_in = 2'($urandom);
      tick();
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if ({gnt_o[k], reg_o[k], done_o[k], busy_o[k], func_o[k], sign_o[k]} !==
            {e_gnt(k), e_reg(k), e_done(k), m_act[k], m_func[k], m_sign[k]}) begin
          tests_failed++;
          $display("FAIL random E=%0d n=%0d: got gnt=%b reg=%b done=%b busy=%b func=%h sign=%b, want gnt=%b reg=%b done=%b busy=%b func=%h sign=%b",
                   m_e[k], n, gnt_o[k], reg_o[k], done_o[k], busy_o[k], func_o[k], sign_o[k],
                   e_gnt(k), e_reg(k), e_done(k), m_act[k], m_func[k], m_sign[k]);
        end
        tests_run++;
        if ($countones(gnt_o[k]) > 1 || $countones(done_o[k]) > 1) begin
          tests_failed++;
          $display("FAIL onehot E=%0d n=%0d: got gnt=%b done=%b, want at most one bit each",
                   m_e[k], n, gnt_o[k], done_o[k]);
        end
      end
    end
    rst = 1'b0; req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_abort();
    test_op_stability();
    test_reset_mid();
    test_latency();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
